// File: rtl/fp32_prep_pkg.sv
// Shared types and field decoding for the single-precision adder preparer.
// Denormals decode to an effective exponent of 1 with the hidden bit cleared.
package fp32_prep_pkg;

    localparam int EXP_W     = 8;
    localparam int MANT_W    = 24;
    localparam int ALIGN_W   = 27;
    localparam int MAX_SHIFT = 27;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        SHIFT,
        DONE
    } state_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp_eff;
        logic [MANT_W-1:0] mant;
        logic              is_special;
    } fp_fields_t;

    function automatic fp_fields_t decode_fp32(input logic [31:0] value);
        fp_fields_t fields;
        fields.sign       = value[31];
        fields.exp_eff    = (value[30:23] == 8'd0) ? 8'd1 : value[30:23];
        fields.mant       = {(value[30:23] != 8'd0), value[22:0]};
        fields.is_special = (value[30:23] == 8'hFF);
        return fields;
    endfunction

endpackage

// File: rtl/align_sequencer_if.sv
// Operand and result handshake bundle between the aligner, its source and the add stage.
interface align_sequencer_if;
    import fp32_prep_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [31:0]        op_a;
    logic [31:0]        op_b;
    logic               out_valid;
    logic               out_ready;
    logic [EXP_W-1:0]   exp_max;
    logic [MANT_W-1:0]  mant_big;
    logic [ALIGN_W-1:0] mant_small;
    logic               sign_big;
    logic               sign_small;
    logic               swap;
    logic               eq;
    logic               special;

    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, exp_max, mant_big, mant_small,
               sign_big, sign_small, swap, eq, special
    );

    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, exp_max, mant_big, mant_small,
               sign_big, sign_small, swap, eq, special
    );

endinterface

// File: rtl/align_sequencer_shifter.sv
// Right shift by a small amount where every bit pushed out of the bottom is
// folded into the sticky bit (bit 0) of the result.
module sticky_shifter
    import fp32_prep_pkg::*;
#(
    parameter int SHIFT_STEP = 4,
    localparam int AMT_W     = $clog2(SHIFT_STEP + 1)
) (
    input  logic [ALIGN_W-1:0] data_i,
    input  logic [AMT_W-1:0]   amount_i,
    output logic [ALIGN_W-1:0] data_o
);

    logic               lost_d;
    logic [ALIGN_W-1:0] shifted_d;

    always_comb begin
        lost_d    = 1'b0;
        shifted_d = data_i >> amount_i;
        for (int i = 0; i < ALIGN_W; i++) begin
            if (i < int'(amount_i)) begin
                lost_d = lost_d | data_i[i];
            end
        end
        data_o = {shifted_d[ALIGN_W-1:1], shifted_d[0] | lost_d};
    end

endmodule

// File: rtl/align_sequencer.sv
// Operand-alignment sequencer: picks the operand with the larger effective exponent
// and walks the smaller mantissa right SHIFT_STEP bits per cycle, keeping G/R/S.
module align_sequencer
    import fp32_prep_pkg::*;
#(
    parameter int SHIFT_STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    align_sequencer_if.slave bus
);

    localparam int         AMT_W    = $clog2(SHIFT_STEP + 1);
    localparam logic [4:0] STEP_AMT = 5'(SHIFT_STEP);

    state_e             state_q;
    logic [31:0]        opA_q;
    logic [31:0]        opB_q;
    logic [4:0]         remaining_q;
    logic [ALIGN_W-1:0] work_q;
    logic [EXP_W-1:0]   expMax_q;
    logic [MANT_W-1:0]  mantBig_q;
    logic               signBig_q;
    logic               signSmall_q;
    logic               swap_q;
    logic               eq_q;
    logic               special_q;
    logic               inReady_q;
    logic               outValid_q;

    fp_fields_t         fieldA_d;
    fp_fields_t         fieldB_d;
    fp_fields_t         fieldBig_d;
    fp_fields_t         fieldSmall_d;
    logic               swap_d;
    logic [EXP_W-1:0]   delta_d;
    logic [4:0]         remInit_d;
    logic [4:0]         step_d;
    logic [ALIGN_W-1:0] shifted_d;

    // Ties keep A as the larger operand; mantissas are never compared.
    always_comb begin
        fieldA_d     = decode_fp32(opA_q);
        fieldB_d     = decode_fp32(opB_q);
        swap_d       = fieldB_d.exp_eff > fieldA_d.exp_eff;
        fieldBig_d   = swap_d ? fieldB_d : fieldA_d;
        fieldSmall_d = swap_d ? fieldA_d : fieldB_d;
        delta_d      = fieldBig_d.exp_eff - fieldSmall_d.exp_eff;
        remInit_d    = (delta_d >= 8'(MAX_SHIFT)) ? 5'(MAX_SHIFT) : delta_d[4:0];
        step_d       = (remaining_q < STEP_AMT) ? remaining_q : STEP_AMT;
    end

    sticky_shifter #(
        .SHIFT_STEP(SHIFT_STEP)
    ) u_shifter (
        .data_i   (work_q),
        .amount_i (AMT_W'(step_d)),
        .data_o   (shifted_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            opA_q       <= '0;
            opB_q       <= '0;
            remaining_q <= '0;
            work_q      <= '0;
            expMax_q    <= '0;
            mantBig_q   <= '0;
            signBig_q   <= 1'b0;
            signSmall_q <= 1'b0;
            swap_q      <= 1'b0;
            eq_q        <= 1'b0;
            special_q   <= 1'b0;
            inReady_q   <= 1'b1;
            outValid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        opA_q     <= bus.op_a;
                        opB_q     <= bus.op_b;
                        inReady_q <= 1'b0;
                        state_q   <= CMP;
                    end
                end
                CMP: begin
                    expMax_q    <= fieldBig_d.exp_eff;
                    mantBig_q   <= fieldBig_d.mant;
                    signBig_q   <= fieldBig_d.sign;
                    signSmall_q <= fieldSmall_d.sign;
                    swap_q      <= swap_d;
                    eq_q        <= (delta_d == 8'd0);
                    special_q   <= fieldBig_d.is_special | fieldSmall_d.is_special;
                    work_q      <= {fieldSmall_d.mant, 3'b000};
                    remaining_q <= remInit_d;
                    state_q     <= (remInit_d == 5'd0) ? DONE : SHIFT;
                end
                SHIFT: begin
                    work_q      <= shifted_d;
                    remaining_q <= remaining_q - step_d;
                    if (remaining_q == step_d) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle raises out_valid; the result then holds until taken.
                    if (!outValid_q) begin
                        outValid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = inReady_q;
    assign bus.out_valid  = outValid_q;
    assign bus.exp_max    = expMax_q;
    assign bus.mant_big   = mantBig_q;
    assign bus.mant_small = work_q;
    assign bus.sign_big   = signBig_q;
    assign bus.sign_small = signSmall_q;
    assign bus.swap       = swap_q;
    assign bus.eq         = eq_q;
    assign bus.special    = special_q;

endmodule

// File: tb/tb_align_sequencer.sv
// Bench for align_sequencer: directed vector table, handshake/reset sequences and
// randomized operand pairs checked against an arithmetic reference model.
module tb_align_sequencer;
    import fp32_prep_pkg::*;

    localparam int STEP    = 4;
    localparam int TIMEOUT = 100;

    typedef struct {
        logic [31:0] opA;
        logic [31:0] opB;
        logic [7:0]  expMax;
        logic [23:0] mantBig;
        logic [26:0] mantSmall;
        logic        signBig;
        logic        signSmall;
        logic        swap;
        logic        eq;
        logic        special;
        int          latency;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checksTotal  = 0;
    int   checksPassed = 0;

    align_sequencer_if bus ();

    align_sequencer #(
        .SHIFT_STEP(STEP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input vec_t e);
        checkValue({tag, ".exp_max"},    32'(bus.exp_max),    32'(e.expMax));
        checkValue({tag, ".mant_big"},   32'(bus.mant_big),   32'(e.mantBig));
        checkValue({tag, ".mant_small"}, 32'(bus.mant_small), 32'(e.mantSmall));
        checkValue({tag, ".sign_big"},   32'(bus.sign_big),   32'(e.signBig));
        checkValue({tag, ".sign_small"}, 32'(bus.sign_small), 32'(e.signSmall));
        checkValue({tag, ".swap"},       32'(bus.swap),       32'(e.swap));
        checkValue({tag, ".eq"},         32'(bus.eq),         32'(e.eq));
        checkValue({tag, ".special"},    32'(bus.special),    32'(e.special));
    endtask

    // Alignment expressed directly as arithmetic on the full mantissa: one shift by the
    // clamped distance, sticky set if any discarded bit was nonzero.
    function automatic vec_t refModel(input logic [31:0] a, input logic [31:0] b);
        vec_t            r;
        int              ea, eb, del, sh;
        longint unsigned ma, mb, ext, res;
        ea = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
        eb = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
        ma = longint'(a[22:0]) + ((a[30:23] == 8'd0) ? 64'd0 : 64'h800000);
        mb = longint'(b[22:0]) + ((b[30:23] == 8'd0) ? 64'd0 : 64'h800000);
        r.opA       = a;
        r.opB       = b;
        r.swap      = (eb > ea);
        r.eq        = (ea == eb);
        del         = r.swap ? eb - ea : ea - eb;
        sh          = (del > 27) ? 27 : del;
        ext         = (r.swap ? ma : mb) * 8;
        res         = ext >> sh;
        if ((ext % (64'd1 << sh)) != 0) res = res | 64'd1;
        r.expMax    = 8'(r.swap ? eb : ea);
        r.mantBig   = 24'(r.swap ? mb : ma);
        r.mantSmall = 27'(res);
        r.signBig   = r.swap ? b[31] : a[31];
        r.signSmall = r.swap ? a[31] : b[31];
        r.special   = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
        r.latency   = 2 + (sh + STEP - 1) / STEP;
        return r;
    endfunction

    // Presents one operand pair, waits for acceptance, then counts edges until out_valid.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, output int latency);
        int waited;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.in_valid = 1'b1;
        waited       = 0;
        while (!bus.in_ready && waited < TIMEOUT) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.in_ready) checkValue("accept_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checkValue("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
        latency = 0;
        do begin
            @(posedge clk); #1;
            latency++;
        end while (!bus.out_valid && latency < TIMEOUT);
    endtask

    task automatic releaseOutput(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checkValue({tag, ".in_ready_after_take"},  32'(bus.in_ready),  32'd1);
        checkValue({tag, ".out_valid_after_take"}, 32'(bus.out_valid), 32'd0);
    endtask

    vec_t        tbl [10];
    vec_t        expv;
    int          lat;
    logic [31:0] a, b;
    logic        sawValid;

    initial begin
        tbl[0] = '{32'h3F800000, 32'h3F800000, 8'h7F, 24'h800000, 27'h4000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        tbl[1] = '{32'h3F800000, 32'h40000000, 8'h80, 24'h800000, 27'h2000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3};
        tbl[2] = '{32'h3F800001, 32'h4B000000, 8'h96, 24'h800000, 27'h0000009, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8};
        tbl[3] = '{32'h3F800000, 32'h7F000000, 8'hFE, 24'h800000, 27'h0000001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9};
        tbl[4] = '{32'h00000001, 32'h00800000, 8'h01, 24'h000001, 27'h4000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        tbl[5] = '{32'h7F800000, 32'h3F800000, 8'hFF, 24'h800000, 27'h0000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9};
        tbl[6] = '{32'hC0400000, 32'h3F000000, 8'h80, 24'hC00000, 27'h1000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        tbl[7] = '{32'h3F800000, 32'h41800000, 8'h83, 24'h800000, 27'h0400000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3};
        tbl[8] = '{32'h3F800000, 32'h42000000, 8'h84, 24'h800000, 27'h0200000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4};
        tbl[9] = '{32'h00000000, 32'h00000000, 8'h01, 24'h000000, 27'h0000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        checkValue("reset.in_ready",   32'(bus.in_ready),   32'd1);
        checkValue("reset.out_valid",  32'(bus.out_valid),  32'd0);
        checkValue("reset.mant_small", 32'(bus.mant_small), 32'd0);
        checkValue("reset.mant_big",   32'(bus.mant_big),   32'd0);
        checkValue("reset.exp_max",    32'(bus.exp_max),    32'd0);

        $display("[TB] directed vectors");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].opA, tbl[i].opB, lat);
            checkValue($sformatf("vec%0d.latency", i), 32'(lat), 32'(tbl[i].latency));
            checkOutput($sformatf("vec%0d", i), tbl[i]);
            if (i == 2) begin
                // Result must sit unchanged while the add stage stalls.
                for (int h = 0; h < 5; h++) begin
                    @(posedge clk); #1;
                    checkOutput($sformatf("hold%0d", h), tbl[i]);
                    checkValue($sformatf("hold%0d.in_ready", h),  32'(bus.in_ready),  32'd0);
                    checkValue($sformatf("hold%0d.out_valid", h), 32'(bus.out_valid), 32'd1);
                end
            end
            releaseOutput($sformatf("vec%0d", i));
        end

        $display("[TB] reset during shift");
        bus.op_a     = 32'h3F800001;
        bus.op_b     = 32'h4B000000;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkValue("midreset.in_ready",   32'(bus.in_ready),   32'd1);
        checkValue("midreset.out_valid",  32'(bus.out_valid),  32'd0);
        checkValue("midreset.mant_small", 32'(bus.mant_small), 32'd0);
        sawValid = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) sawValid = 1'b1;
        end
        checkValue("midreset.no_result", 32'(sawValid), 32'd0);

        applyStimulus(tbl[1].opA, tbl[1].opB, lat);
        checkValue("recover.latency", 32'(lat), 32'(tbl[1].latency));
        checkOutput("recover", tbl[1]);
        releaseOutput("recover");

        $display("[TB] randomized pairs");
        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: b[30:23] = a[30:23] + 8'($urandom_range(0, 12));
                1: b[30:23] = a[30:23] - 8'($urandom_range(0, 30));
                2: b[30:23] = 8'd0;
                3: begin
                    a[30:23] = 8'($urandom_range(0, 2));
                    b[30:23] = 8'($urandom_range(0, 2));
                end
                default: ;
            endcase
            expv = refModel(a, b);
            applyStimulus(a, b, lat);
            checkValue($sformatf("rand%0d.latency", n), 32'(lat), 32'(expv.latency));
            checkOutput($sformatf("rand%0d", n), expv);
            releaseOutput($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
